// File: rtl/demux1an_param_cond.sv
// ----------------------------------------------------------------------------
// demux1an_param_cond
// Round-robin 1-to-NCH demultiplexer with frame realignment.
// Each valid word lands on the lane held in ptr, or on lane 0 when sync_in is
// set. The pointer moves only on accepted words, so idle cycles keep the
// lane mapping intact.
//
// Ports
//   clk_2f     : clock, all state updates on the rising edge
//   reset_L    : asynchronous active-low reset
//   valid      : data_in carries a word this cycle
//   data_in    : input word (WIDTH bits)
//   sync_in    : with valid, forces the current word onto lane 0
//   data_out   : NCH lanes, lane i at [i*WIDTH +: WIDTH], holds last value
//   validout   : one-cycle pulse per lane when that lane was written
//   frame_done : one-cycle pulse when lane NCH-1 was written
//   frame_err  : one-cycle pulse when sync_in arrived mid-frame (ptr != 0)
//   ptr        : next lane to be written
// ----------------------------------------------------------------------------
module demux1an_param_cond #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned NCH   = 4,
   localparam int unsigned PW    = $clog2(NCH)
) (
   input  logic                   clk_2f,
   input  logic                   reset_L,
   input  logic                   valid,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   sync_in,
   output logic [NCH*WIDTH-1:0]   data_out,
   output logic [NCH-1:0]         validout,
   output logic                   frame_done,
   output logic                   frame_err,
   output logic [PW-1:0]          ptr
);

   localparam int unsigned LAST_LANE = NCH - 1;

   logic [WIDTH-1:0] lane_q [NCH];

   logic [PW-1:0]  target_c;
   logic [PW-1:0]  ptr_next_c;
   logic [NCH-1:0] hit_c;
   logic           done_c;
   logic           err_c;

   // Lane selection and next-pointer computation for the current word.
   always_comb begin
      target_c   = ptr;
      ptr_next_c = ptr;
      hit_c      = '0;
      done_c     = 1'b0;
      err_c      = 1'b0;
      if (sync_in) begin
         target_c = '0;
      end
      if (valid) begin
         // A sync word occupies lane 0, so the frame resumes at lane 1.
         ptr_next_c = target_c + PW'(1);
         hit_c      = NCH'(1) << target_c;
         done_c     = (target_c == PW'(LAST_LANE));
         err_c      = sync_in && (ptr != '0);
      end
   end

   // Pointer and per-word status flags; flags clear on every non-accepting edge.
   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         ptr        <= '0;
         validout   <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         ptr        <= ptr_next_c;
         validout   <= hit_c;
         frame_done <= done_c;
         frame_err  <= err_c;
      end
   end

   // Lane data registers; only the targeted lane loads.
   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < int'(NCH); i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NCH); i++) begin
            if (hit_c[i]) begin
               lane_q[i] <= data_in;
            end
         end
      end
   end

   // Flatten lane registers onto the output bus.
   for (genvar g = 0; g < int'(NCH); g++) begin : g_lane
      assign data_out[g*WIDTH +: WIDTH] = lane_q[g];
   end

endmodule

// File: tb/tb_demux1an_param_cond.sv
module tb_demux1an_param_cond;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- main instance: WIDTH=8, NCH=4 ----------------
   logic        v  = 1'b0;
   logic        s  = 1'b0;
   logic [7:0]  d  = '0;
   logic [31:0] dout;
   logic [3:0]  vo;
   logic        fd, fe;
   logic [1:0]  p;

   demux1an_param_cond #(.WIDTH(8), .NCH(4)) u_dut (
      .clk_2f(clk), .reset_L(rst_n), .valid(v), .data_in(d), .sync_in(s),
      .data_out(dout), .validout(vo), .frame_done(fd), .frame_err(fe), .ptr(p)
   );

   // Behavioural model: words counted from the start of the current frame.
   int         m_lane [4];
   int         m_pos  = 0;
   logic [3:0] m_vo   = '0;
   logic       m_done = 1'b0;
   logic       m_err  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) m_lane[i] = 0;
         m_pos = 0; m_vo = '0; m_done = 1'b0; m_err = 1'b0;
      end else begin
         m_vo = '0; m_done = 1'b0; m_err = 1'b0;
         if (v) begin
            if (s) begin
               m_err = (m_pos % 4) != 0;
               m_lane[0] = int'(d);
               m_vo[0] = 1'b1;
               m_pos = 1;
            end else begin
               m_lane[m_pos % 4] = int'(d);
               m_vo[m_pos % 4] = 1'b1;
               m_done = (m_pos % 4) == 3;
               m_pos = m_pos + 1;
            end
         end
      end
   end

   // Per-cycle comparison of the main instance against the model.
   always @(negedge clk) begin
      logic [31:0] exp_d;
      for (int i = 0; i < 4; i++) exp_d[i*8 +: 8] = 8'(m_lane[i]);
      chk("cyc_data_out",   512'(dout), 512'(exp_d));
      chk("cyc_validout",   512'(vo),   512'(m_vo));
      chk("cyc_frame_done", 512'(fd),   512'(m_done));
      chk("cyc_frame_err",  512'(fe),   512'(m_err));
      chk("cyc_ptr",        512'(p),    512'(m_pos % 4));
   end

   task automatic send(input logic vv, input logic ss, input logic [7:0] dd);
      v = vv; s = ss; d = dd;
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- sweep instances ----------------
   logic         v2 = 1'b0, s2 = 1'b0;
   logic [3:0]   d2 = '0;
   logic [7:0]   dout2;
   logic [1:0]   vo2;
   logic         fd2, fe2;
   logic [0:0]   p2;

   demux1an_param_cond #(.WIDTH(4), .NCH(2)) u_dut2 (
      .clk_2f(clk), .reset_L(rst_n), .valid(v2), .data_in(d2), .sync_in(s2),
      .data_out(dout2), .validout(vo2), .frame_done(fd2), .frame_err(fe2), .ptr(p2)
   );

   logic         v16 = 1'b0, s16 = 1'b0;
   logic [31:0]  d16 = '0;
   logic [511:0] dout16;
   logic [15:0]  vo16;
   logic         fd16, fe16;
   logic [3:0]   p16;

   demux1an_param_cond #(.WIDTH(32), .NCH(16)) u_dut16 (
      .clk_2f(clk), .reset_L(rst_n), .valid(v16), .data_in(d16), .sync_in(s16),
      .data_out(dout16), .validout(vo16), .frame_done(fd16), .frame_err(fe16), .ptr(p16)
   );

   int n_fd2 = 0, n_fd16 = 0, n_fe2 = 0, n_fe16 = 0;
   always @(negedge clk) begin
      if (fd2)  n_fd2++;
      if (fd16) n_fd16++;
      if (fe2)  n_fe2++;
      if (fe16) n_fe16++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [3:0]   w2  [5];
      logic [31:0]  w16 [33];
      logic [7:0]   exp2;
      logic [511:0] exp16;

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_data_out", 512'(dout), 512'(0));
      chk("rst_validout", 512'(vo),   512'(0));
      chk("rst_ptr",      512'(p),    512'(0));
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fill and wrap
      send(1, 0, 8'h11); chk("fill_vo0", 512'(vo), 512'(4'b0001));
      send(1, 0, 8'h22); chk("fill_vo1", 512'(vo), 512'(4'b0010));
      send(1, 0, 8'h33); chk("fill_vo2", 512'(vo), 512'(4'b0100));
      chk("fill_no_done", 512'(fd), 512'(0));
      send(1, 0, 8'h44); chk("fill_vo3", 512'(vo), 512'(4'b1000));
      chk("fill_done", 512'(fd), 512'(1));
      chk("fill_lanes", 512'(dout), 512'(32'h44332211));
      send(1, 0, 8'h55);
      chk("wrap_lanes", 512'(dout), 512'(32'h44332255));
      chk("wrap_ptr",   512'(p),    512'(1));
      chk("wrap_done",  512'(fd),   512'(0));

      // Resync and error, lane 2 keeps its old value
      send(1, 0, 8'h66); chk("pre_sync_ptr", 512'(p), 512'(2));
      send(1, 1, 8'h77);
      chk("sync_lanes", 512'(dout), 512'(32'h44336677));
      chk("sync_err",   512'(fe),   512'(1));
      chk("sync_ptr",   512'(p),    512'(1));
      send(0, 0, 8'h00); chk("sync_err_clear", 512'(fe), 512'(0));

      // Sync at ptr=NCH-1: error, no frame_done
      send(1, 0, 8'h88);
      send(1, 0, 8'h99); chk("ptr3", 512'(p), 512'(3));
      send(1, 1, 8'hAA);
      chk("last_sync_err",  512'(fe),   512'(1));
      chk("last_sync_done", 512'(fd),   512'(0));
      chk("last_sync_ptr",  512'(p),    512'(1));
      chk("last_sync_lanes", 512'(dout), 512'(32'h449988AA));

      // Ignored sync with valid=0
      send(0, 1, 8'hFF);
      chk("ign_ptr",   512'(p),    512'(1));
      chk("ign_vo",    512'(vo),   512'(0));
      chk("ign_err",   512'(fe),   512'(0));
      chk("ign_lanes", 512'(dout), 512'(32'h449988AA));

      // Asynchronous reset mid-frame
      send(1, 0, 8'hBB);
      chk("pre_rst_vo", 512'(vo), 512'(4'b0010));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data_out", 512'(dout), 512'(0));
      chk("arst_validout", 512'(vo),   512'(0));
      chk("arst_ptr",      512'(p),    512'(0));
      @(negedge clk);
      rst_n = 1'b1;
      send(1, 0, 8'hA5);
      chk("post_rst_lanes", 512'(dout), 512'(32'h000000A5));
      chk("post_rst_vo",    512'(vo),   512'(4'b0001));

      // Legal sync at ptr=0
      send(1, 0, 8'hB1); send(1, 0, 8'hB2); send(1, 0, 8'hB3);
      chk("legal_pre_ptr", 512'(p), 512'(0));
      send(1, 1, 8'hC0);
      chk("legal_sync_err", 512'(fe), 512'(0));
      chk("legal_sync_ptr", 512'(p),  512'(1));

      // Gaps
      send(1, 0, 8'hC1); send(1, 0, 8'hC2); send(1, 0, 8'hC3);
      send(1, 0, 8'h01);
      for (int i = 0; i < 3; i++) begin
         send(0, 0, 8'h00);
         chk("gap_vo",  512'(vo), 512'(0));
         chk("gap_ptr", 512'(p),  512'(1));
      end
      send(1, 0, 8'h02);
      send(0, 0, 8'h00);
      send(1, 0, 8'h03);
      chk("gap_lanes", 512'(dout), 512'(32'hC3030201));
      send(0, 0, 8'h00);

      // Sweep NCH=2, WIDTH=4
      n_fd2 = 0; n_fe2 = 0;
      for (int i = 0; i < 5; i++) begin
         w2[i] = 4'($urandom);
         v2 = 1'b1; d2 = w2[i];
         @(posedge clk); @(negedge clk);
      end
      v2 = 1'b0;
      @(negedge clk);
      exp2 = '0;
      for (int i = 0; i < 5; i++) exp2[(i % 2)*4 +: 4] = w2[i];
      chk("sw2_lanes", 512'(dout2), 512'(exp2));
      chk("sw2_done_cnt", 512'(n_fd2), 512'(2));
      chk("sw2_err_cnt",  512'(n_fe2), 512'(0));
      chk("sw2_ptr",      512'(p2),    512'(1));

      // Sweep NCH=16, WIDTH=32
      n_fd16 = 0; n_fe16 = 0;
      for (int i = 0; i < 33; i++) begin
         w16[i] = $urandom;
         v16 = 1'b1; d16 = w16[i];
         @(posedge clk); @(negedge clk);
      end
      v16 = 1'b0;
      @(negedge clk);
      exp16 = '0;
      for (int i = 0; i < 33; i++) exp16[(i % 16)*32 +: 32] = w16[i];
      chk("sw16_lanes", dout16, exp16);
      chk("sw16_done_cnt", 512'(n_fd16), 512'(2));
      chk("sw16_err_cnt",  512'(n_fe16), 512'(0));
      chk("sw16_ptr",      512'(p16),    512'(1));

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/demux1an_param_cond.md
# demux1aN_param_cond

Parametrised 1-to-N round-robin demultiplexer on the fast clock domain. Each valid input word goes to the next output lane in order (lane 0, 1, …, NCH-1, then back to 0). The lane pointer advances only on accepted words, so gaps in `valid` do not shift the mapping. Extends the fixed 1-to-2 demux with:
- configurable width and lane count;
- frame realignment via `sync_in`;
- frame-complete and misalignment flags.

## Interface
- `WIDTH`, default 8: bits per data word; legal 1..64.
- `NCH`, default 4: number of output lanes; power of two, legal 2..16.
- `PW`, localparam = log2(NCH): pointer width. Not user-overridable.

Ports (name, direction, width, meaning):
- `clk_2f`, in, 1: single clock; all state updates on its rising edge.
- `reset_L`, in, 1: reset, asynchronous and active-low.
- `valid`, in, 1: `data_in` carries a word this cycle.
- `data_in`, in, WIDTH: input word.
- `sync_in`, in, 1: qualified by `valid`; forces the current word to lane 0.
- `data_out`, out, NCH*WIDTH: lane i occupies bits [i*WIDTH +: WIDTH]; registered, holds last value.
- `validout`, out, NCH: bit i is a one-cycle pulse when lane i is updated.
- `frame_done`, out, 1: one-cycle pulse when lane NCH-1 is written.
- `frame_err`, out, 1: one-cycle pulse on `sync_in` with pointer ≠ 0.
- `ptr`, out, PW: current lane pointer (next lane to be written).

## Operation
- **State:** pointer `ptr` (PW bits), NCH data registers, and registered flag outputs `validout`, `frame_done`, `frame_err`.
- **Accept:** a word is accepted on any rising edge with `valid`=1. There is no backpressure; every valid word is accepted.
- **Target lane:**
  - `sync_in`=1: lane 0.
  - `sync_in`=0: lane `ptr`.
- **Lane update:** the target lane register loads `data_in`. All other lanes hold their value.
- **validout:** `validout` = one-hot of the target lane. It is all-zero on cycles with no accept.
- **Pointer update:**
  - Normal accept: `ptr` ← target+1, modulo NCH. Wrap from NCH-1 to 0 is natural binary overflow.
  - `sync_in` accept: `ptr` ← 1.
  - `valid`=0: `ptr` holds. `sync_in` is ignored when `valid`=0.
- **frame_done:** pulses when the target lane = NCH-1, including a sync word when NCH would make lane 0 = NCH-1 (not possible for NCH ≥ 2).
- **frame_err:**
  - Pulses when `valid`=1, `sync_in`=1 and `ptr` ≠ 0; the partial frame is abandoned.
  - `sync_in` with `ptr`=0 is legal and raises no error.
- **Mode-free:** no operating modes; behaviour is fully determined by `valid`/`sync_in`.
- **Reset (asynchronous assert, `reset_L`=0):**
  - All `data_out` lanes = 0.
  - `validout` = 0, `frame_done` = 0, `frame_err` = 0, `ptr` = 0.
  - Takes effect immediately, independent of `clk_2f`.
- **Reset mid-frame:** the partial frame is discarded. The first valid word after release goes to lane 0.
- **Reset release:** synchronous use only. The first edge with `reset_L`=1 may accept a word.

## Timing
- **Latency:** 1 cycle. A word accepted at edge k appears on its lane, with its `validout` bit, `frame_done` and `frame_err`, after edge k. These outputs are valid during cycle k+1.
- **Throughput:** one word per clock. Back-to-back valid words fill lanes on consecutive cycles.
- **Flag pulses:** `validout`, `frame_done` and `frame_err` are high for exactly one cycle per accepting edge. They are low after any edge without an accept.
- **ptr:** registered; reflects the post-edge value.
- **Same-cycle events:** `sync_in`, wrap and `frame_err` can coincide. Example: `ptr`=NCH-1 with sync gives lane 0, `frame_err`=1, `frame_done`=0 and `ptr`=1.
- **Output paths:** purely registered; no combinational input-to-output path.

## Test plan
- **Reset values:** assert `reset_L`=0 mid-stream → immediately all `data_out`=0, `validout`=0, `ptr`=0. After release, the first word, 0xA5, appears on lane 0.
- **Fill and wrap:** WIDTH=8, NCH=4. Valid words 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles → lanes 0..3 = 0x11..0x44 and `validout` pulses 0001, 0010, 0100, 1000. `frame_done` pulses after the 4th word. Lane 0 then becomes 0x55 and `ptr` ends at 1.
- **Gaps:** words 0x01, gap of 3 cycles, 0x02, gap, 0x03 → lanes 0..2 = 0x01, 0x02, 0x03. `validout` is 0 during gaps and `ptr` holds across them.
- **Resync and error:** after 2 words (`ptr`=2), send 0x77 with `sync_in` → lane 0 = 0x77, `frame_err` pulses once, `ptr`=1. Lane 2 keeps its old value.
- **Legal sync and ignored sync:** `sync_in` with `ptr`=0 → no `frame_err`. `sync_in`=1 with `valid`=0 → no state change.
- **Parameter sweep:** NCH=2 with WIDTH=4, and NCH=16 with WIDTH=32, each fed 2*NCH+1 random words → lane j holds the last word whose index mod NCH = j. There are exactly 2 `frame_done` pulses.
